// File: rtl/mux4_rr_arbiter_pkg.sv
// arb_pkg: shared sizes and output-stage state for mux4_rr_arbiter.
package arb_pkg;
    localparam int NUM_REQ = 4;
    localparam int PTR_W   = 2;
    typedef enum logic {EMPTY, FULL} state_e;
endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// mux4_rr_arbiter_if: requester and consumer signals of the arbiter; Lock exists only with ARB_LOCK_EN.
interface mux4_rr_arbiter_if #(parameter int DATA_WIDTH = 32);
    import arb_pkg::*;
    logic [NUM_REQ-1:0]    Req;
    logic [DATA_WIDTH-1:0] InA, InB, InC, InD;
    logic [NUM_REQ-1:0]    Ack;
    logic [PTR_W-1:0]      Sel;
    logic [DATA_WIDTH-1:0] OutData;
    logic                  OutValid;
    logic                  OutReady;
`ifdef ARB_LOCK_EN
    logic [NUM_REQ-1:0]    Lock;
    modport master (input Req, InA, InB, InC, InD, OutReady, Lock, output Ack, Sel, OutData, OutValid);
    modport slave  (output Req, InA, InB, InC, InD, OutReady, Lock, input Ack, Sel, OutData, OutValid);
`else
    modport master (input Req, InA, InB, InC, InD, OutReady, output Ack, Sel, OutData, OutValid);
    modport slave  (output Req, InA, InB, InC, InD, OutReady, input Ack, Sel, OutData, OutValid);
`endif
endinterface

// File: rtl/mux4_rr_arbiter_rr_pick.sv
// rr_pick: rotate-priority encoder; first set bit of E scanning Ptr, Ptr+1, ... mod 4.
module rr_pick
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] E,
    input  logic [PTR_W-1:0]   Ptr,
    output logic [PTR_W-1:0]   Grant,
    output logic               Any
);
    always_comb begin
        Any   = |E;
        Grant = Ptr;
        // Scan backwards so the candidate nearest Ptr is written last and wins.
        for (int k = NUM_REQ - 1; k >= 0; k--)
            if (E[Ptr + PTR_W'(k)]) Grant = Ptr + PTR_W'(k);
    end
endmodule

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin 4:1 word arbiter with a one-entry valid/ready output stage.
// Define ARB_LOCK_EN to add the Lock input that lets a winner keep the channel.
module mux4_rr_arbiter
    import arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int RESET_PTR  = 0
) (
    input logic                Clk,
    input logic                Reset_n,
    mux4_rr_arbiter_if.master  bus
);
    state_e                state_q, state_d;
    logic [PTR_W-1:0]      ptr_q, ptr_d, sel_q, sel_d, grant;
    logic [NUM_REQ-1:0]    ack_q, ack_d, elig;
    logic [DATA_WIDTH-1:0] data_q, data_d, mux_data;
    logic                  any, cap;
`ifdef ARB_LOCK_EN
    logic                  lock_q, lock_d;
    logic [PTR_W-1:0]      owner_q, owner_d;
    assign elig = bus.Req & ~ack_q & (lock_q ? NUM_REQ'(1) << owner_q : '1);
`else
    assign elig = bus.Req & ~ack_q;
`endif
    rr_pick u_pick (.E(elig), .Ptr(ptr_q), .Grant(grant), .Any(any));
    assign mux_data = grant == 2'd0 ? bus.InA :
                      grant == 2'd1 ? bus.InB :
                      grant == 2'd2 ? bus.InC : bus.InD;
    assign cap = any & (state_q == EMPTY | bus.OutReady);
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        data_d  = data_q;
        ack_d   = '0;
`ifdef ARB_LOCK_EN
        lock_d  = lock_q;
        owner_d = owner_q;
`endif
        if (cap) begin
            state_d = FULL;
            sel_d   = grant;
            data_d  = mux_data;
            ack_d   = NUM_REQ'(1) << grant;
            ptr_d   = grant + 2'd1;
`ifdef ARB_LOCK_EN
            lock_d  = bus.Lock[grant];
            owner_d = grant;
            ptr_d   = bus.Lock[grant] ? ptr_q : grant + 2'd1;
`endif
        end else if (state_q == FULL && bus.OutReady) begin
            state_d = EMPTY;
        end
    end
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q <= EMPTY;
            ptr_q   <= PTR_W'(RESET_PTR);
            sel_q   <= '0;
            data_q  <= '0;
            ack_q   <= '0;
`ifdef ARB_LOCK_EN
            lock_q  <= 1'b0;
            owner_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            ack_q   <= ack_d;
`ifdef ARB_LOCK_EN
            lock_q  <= lock_d;
            owner_q <= owner_d;
`endif
        end
    end
    assign bus.Ack      = ack_q;
    assign bus.Sel      = sel_q;
    assign bus.OutData  = data_q;
    assign bus.OutValid = state_q == FULL;
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb_mux4_rr_arbiter: directed-vector bench for mux4_rr_arbiter; lock steps run only with ARB_LOCK_EN.
module tb_mux4_rr_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   passed = 0;
    mux4_rr_arbiter_if bus ();
    mux4_rr_arbiter #(.DATA_WIDTH(32), .RESET_PTR(0)) dut (.Clk(clk), .Reset_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask
    task automatic chk_out(input string tag, input logic v, input logic [1:0] s, input logic [3:0] a, input logic [31:0] d);
        chk({tag, ".valid"}, 32'(bus.OutValid), 32'(v));
        chk({tag, ".sel"},   32'(bus.Sel),      32'(s));
        chk({tag, ".ack"},   32'(bus.Ack),      32'(a));
        chk({tag, ".data"},  bus.OutData,       d);
    endtask
    initial begin
        bus.Req = 4'hF; bus.OutReady = 1'b1;
        bus.InA = 32'hAAAA0000; bus.InB = 32'hBBBB0001; bus.InC = 32'hCCCC0002; bus.InD = 32'hDDDD0003;
`ifdef ARB_LOCK_EN
        bus.Lock = 4'b0000;
`endif
        tick(); tick();
        chk_out("reset", 1'b0, 2'd0, 4'b0000, 32'h0);
        rst_n = 1'b1;
        tick();
        chk_out("first", 1'b1, 2'd0, 4'b0001, 32'hAAAA0000);
        bus.Req = 4'b1110; tick();
        chk_out("rr1", 1'b1, 2'd1, 4'b0010, 32'hBBBB0001);
        bus.Req = 4'b1100; tick();
        chk_out("rr2", 1'b1, 2'd2, 4'b0100, 32'hCCCC0002);
        bus.Req = 4'b1000; tick();
        chk_out("rr3", 1'b1, 2'd3, 4'b1000, 32'hDDDD0003);
        bus.Req = 4'b0000; tick();
        chk_out("drain", 1'b0, 2'd3, 4'b0000, 32'hDDDD0003);
        bus.Req = 4'hF; tick();
        chk_out("wrap", 1'b1, 2'd0, 4'b0001, 32'hAAAA0000);
        bus.InB = 32'h12345678; bus.Req = 4'b0010; tick();
        chk_out("bp_cap", 1'b1, 2'd1, 4'b0010, 32'h12345678);
        bus.Req = 4'b0100; bus.OutReady = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_out("bp_hold", 1'b1, 2'd1, 4'b0000, 32'h12345678);
        end
        bus.OutReady = 1'b1; tick();
        chk_out("bp_release", 1'b1, 2'd2, 4'b0100, 32'hCCCC0002);
        bus.Req = 4'b1010;
        tick(); chk_out("b2b0", 1'b1, 2'd3, 4'b1000, 32'hDDDD0003);
        tick(); chk_out("b2b1", 1'b1, 2'd1, 4'b0010, 32'h12345678);
        tick(); chk_out("b2b2", 1'b1, 2'd3, 4'b1000, 32'hDDDD0003);
        tick(); chk_out("b2b3", 1'b1, 2'd1, 4'b0010, 32'h12345678);
        bus.InC = 32'hDEADBEEF; bus.Req = 4'b0100; tick();
        chk_out("pre_rst", 1'b1, 2'd2, 4'b0100, 32'hDEADBEEF);
        bus.Req = 4'b0000; bus.OutReady = 1'b0; rst_n = 1'b0; tick();
        chk_out("mid_rst", 1'b0, 2'd0, 4'b0000, 32'h0);
        rst_n = 1'b1; bus.OutReady = 1'b1; tick();
        chk_out("post_rst_idle", 1'b0, 2'd0, 4'b0000, 32'h0);
        bus.Req = 4'b1010; tick();
        chk_out("post_rst_ptr", 1'b1, 2'd1, 4'b0010, 32'h12345678);
`ifdef ARB_LOCK_EN
        bus.Req = 4'b0000; rst_n = 1'b0; tick();
        rst_n = 1'b1; bus.Req = 4'b1101; bus.Lock = 4'b0100; tick();
        chk_out("lk_c1", 1'b1, 2'd0, 4'b0001, 32'hAAAA0000);
        tick(); chk_out("lk_c2", 1'b1, 2'd2, 4'b0100, 32'hDEADBEEF);
        tick(); chk_out("lk_gap1", 1'b0, 2'd2, 4'b0000, 32'hDEADBEEF);
        tick(); chk_out("lk_c3", 1'b1, 2'd2, 4'b0100, 32'hDEADBEEF);
        tick(); chk_out("lk_gap2", 1'b0, 2'd2, 4'b0000, 32'hDEADBEEF);
        tick(); chk_out("lk_c4", 1'b1, 2'd2, 4'b0100, 32'hDEADBEEF);
        tick(); bus.Lock = 4'b0000;
        tick(); chk_out("lk_c5", 1'b1, 2'd2, 4'b0100, 32'hDEADBEEF);
        tick(); chk_out("lk_free", 1'b1, 2'd3, 4'b1000, 32'hDDDD0003);
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
